decoded_inst_queue: RTL and testbench

- Buffer directly downstream of the Decode_Unit output mux, upstream of dispatch/rename.
- Absorbs decoded micro-ops, decouples the 3-stage decode pipe from dispatch backpressure, and generates the stall_i feeding decode.
- Circular FIFO with a threshold-based early stall that covers the decode in-flight skid.
- Supports a full flush on redirect.

---
 rtl/decode_pkg.sv | 32 +++
 rtl/decoded_inst_queue_ram.sv | 26 ++
 rtl/decoded_inst_queue.sv | 168 ++++++++++++++++
 tb/tb_decoded_inst_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: operand/field width constants and the packed decoded-instruction
// entry used by the Decode_Unit output mux, the decoded instruction queue and dispatch.
package decode_pkg;

   localparam int unsigned addressWidth            = 64;
   localparam int unsigned opcodeSize              = 6;
   localparam int unsigned funcUnitCodeSize        = 3;
   localparam int unsigned instructionCounterWidth = 64;
   localparam int unsigned instMinIdWidth          = 4;
   localparam int unsigned PidSize                 = 20;
   localparam int unsigned TidSize                 = 16;
   localparam int unsigned regAccessPatternSize    = 2;
   localparam int unsigned bodyWidth               = 84;

   // op_rw[0] / op_is_reg[0] belong to operand 1.
   typedef struct packed {
      logic [opcodeSize-1:0]                       opcode;
      logic [addressWidth-1:0]                     address;
      logic [funcUnitCodeSize-1:0]                 func_unit;
      logic [instructionCounterWidth-1:0]          maj_id;
      logic [instMinIdWidth-1:0]                   min_id;
      logic                                        is_64bit;
      logic [PidSize-1:0]                          pid;
      logic [TidSize-1:0]                          tid;
      logic [3:0][regAccessPatternSize-1:0]        op_rw;
      logic [3:0]                                  op_is_reg;
      logic [bodyWidth-1:0]                        body;
   } decoded_inst_t;

   localparam int unsigned DecodedInstWidth = $bits(decoded_inst_t);

endpackage

// File: rtl/decoded_inst_queue_ram.sv
// Entry storage for the decoded instruction queue.
// Ports: clk (clock), wr_en/wr_addr/wr_data (synchronous write port),
//        rd_addr/rd_data (combinational read port).
module decoded_inst_queue_ram #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 274
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(Depth)-1:0] wr_addr,
   input  logic [Width-1:0]         wr_data,
   input  logic [$clog2(Depth)-1:0] rd_addr,
   output logic [Width-1:0]         rd_data
);

   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/decoded_inst_queue.sv
// Decoded instruction queue: circular FIFO between decode and dispatch/rename. Generates an early
// stall to decode once occupancy leaves only skidSlots free entries, so the decode in-flight
// instructions still fit. Full flush on redirect.
// Ports: clock_i, reset_i (sync, active-low), flush_i; enable_i + decoded fields (*_i) push an
// entry; valid_o + head fields (*_o) + dispatchReady_i form the dispatch handshake; stall_o,
// overflow_o (sticky dropped push), count_o (occupancy).
// Optional: define DECODED_QUEUE_PERF_EN to add saturating pushCount_o, popCount_o and
// stallCycles_o counters (cleared by reset only).
module decoded_inst_queue #(
   parameter int unsigned addressWidth            = decode_pkg::addressWidth,
   parameter int unsigned opcodeSize              = decode_pkg::opcodeSize,
   parameter int unsigned funcUnitCodeSize        = decode_pkg::funcUnitCodeSize,
   parameter int unsigned instructionCounterWidth = decode_pkg::instructionCounterWidth,
   parameter int unsigned instMinIdWidth          = decode_pkg::instMinIdWidth,
   parameter int unsigned PidSize                 = decode_pkg::PidSize,
   parameter int unsigned TidSize                 = decode_pkg::TidSize,
   parameter int unsigned regAccessPatternSize    = decode_pkg::regAccessPatternSize,
   parameter int unsigned bodyWidth               = decode_pkg::bodyWidth,
   parameter int unsigned queueDepth              = 8,
   parameter int unsigned skidSlots               = 3
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               enable_i,
   input  logic [opcodeSize-1:0]              opcode_i,
   input  logic [addressWidth-1:0]            address_i,
   input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
   input  logic [instructionCounterWidth-1:0] majID_i,
   input  logic [instMinIdWidth-1:0]          minID_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 pid_i,
   input  logic [TidSize-1:0]                 tid_i,
   input  logic [regAccessPatternSize-1:0]    op1rw_i,
   input  logic [regAccessPatternSize-1:0]    op2rw_i,
   input  logic [regAccessPatternSize-1:0]    op3rw_i,
   input  logic [regAccessPatternSize-1:0]    op4rw_i,
   input  logic                               op1IsReg_i,
   input  logic                               op2IsReg_i,
   input  logic                               op3IsReg_i,
   input  logic                               op4IsReg_i,
   input  logic [bodyWidth-1:0]               body_i,
   output logic                               stall_o,
   output logic                               overflow_o,
   output logic                               valid_o,
   input  logic                               dispatchReady_i,
   output logic [opcodeSize-1:0]              opcode_o,
   output logic [addressWidth-1:0]            address_o,
   output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
   output logic [instructionCounterWidth-1:0] majID_o,
   output logic [instMinIdWidth-1:0]          minID_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 pid_o,
   output logic [TidSize-1:0]                 tid_o,
   output logic [regAccessPatternSize-1:0]    op1rw_o,
   output logic [regAccessPatternSize-1:0]    op2rw_o,
   output logic [regAccessPatternSize-1:0]    op3rw_o,
   output logic [regAccessPatternSize-1:0]    op4rw_o,
   output logic                               op1IsReg_o,
   output logic                               op2IsReg_o,
   output logic                               op3IsReg_o,
   output logic                               op4IsReg_o,
   output logic [bodyWidth-1:0]               body_o,
   output logic [$clog2(queueDepth):0]        count_o
`ifdef DECODED_QUEUE_PERF_EN
   ,
   output logic [31:0]                        pushCount_o,
   output logic [31:0]                        popCount_o,
   output logic [31:0]                        stallCycles_o
`endif
);

   localparam int unsigned PtrWidth   = $clog2(queueDepth);
   localparam int unsigned CntWidth   = PtrWidth + 1;
   localparam int unsigned EntryWidth = opcodeSize + addressWidth + funcUnitCodeSize +
                                        instructionCounterWidth + instMinIdWidth + 1 + PidSize +
                                        TidSize + 4 * regAccessPatternSize + 4 + bodyWidth;

   logic [PtrWidth-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CntWidth-1:0]   count_q, count_d;
   logic                  stall_q, overflow_q;
   logic                  push, pop, valid;
   logic [EntryWidth-1:0] wr_entry, rd_entry, head;

   assign valid = (count_q != '0);
   assign pop   = valid & dispatchReady_i;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push  = enable_i & ((count_q < CntWidth'(queueDepth)) | pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CntWidth'(1);
         2'b01:   count_d = count_q - CntWidth'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
         count_q <= count_d;
         stall_q <= (count_d >= CntWidth'(queueDepth - skidSlots));
         if (enable_i && !push) overflow_q <= 1'b1;
      end
   end

   assign wr_entry = {opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i, pid_i,
                      tid_i, op4rw_i, op3rw_i, op2rw_i, op1rw_i,
                      op4IsReg_i, op3IsReg_i, op2IsReg_i, op1IsReg_i, body_i};

   decoded_inst_queue_ram #(
      .Depth (queueDepth),
      .Width (EntryWidth)
   ) u_ram (
      .clk     (clock_i),
      .wr_en   (push & ~flush_i & reset_i),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_entry)
   );

   // Stale storage must not leak onto the head fields while empty.
   assign head = valid ? rd_entry : '0;

   assign {opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o, pid_o,
           tid_o, op4rw_o, op3rw_o, op2rw_o, op1rw_o,
           op4IsReg_o, op3IsReg_o, op2IsReg_o, op1IsReg_o, body_o} = head;

   assign valid_o    = valid;
   assign stall_o    = stall_q;
   assign overflow_o = overflow_q;
   assign count_o    = count_q;

`ifdef DECODED_QUEUE_PERF_EN
   logic [31:0] push_cnt_q, pop_cnt_q, stall_cnt_q;

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         push_cnt_q  <= '0;
         pop_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (push && !flush_i && push_cnt_q != '1) push_cnt_q  <= push_cnt_q + 32'd1;
         if (pop && !flush_i && pop_cnt_q != '1)   pop_cnt_q   <= pop_cnt_q + 32'd1;
         if (stall_q && stall_cnt_q != '1)         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign pushCount_o   = push_cnt_q;
   assign popCount_o    = pop_cnt_q;
   assign stallCycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decoded_inst_queue.sv
// Bench for decoded_inst_queue: directed push/pop/flush/reset sequences. Expected entries go
// into a scoreboard queue when the bench issues a push; a monitor pops and compares on every
// dispatch handshake. Occupancy/status flags are checked against a small reference model.
module tb_decoded_inst_queue;
   import decode_pkg::*;

   logic         clock_i = 1'b0;
   logic         reset_i, flush_i, enable_i, dispatchReady_i;
   logic [5:0]   opcode_i, opcode_o;
   logic [63:0]  address_i, address_o, majID_i, majID_o;
   logic [2:0]   funcUnitType_i, funcUnitType_o;
   logic [3:0]   minID_i, minID_o;
   logic         is64Bit_i, is64Bit_o;
   logic [19:0]  pid_i, pid_o;
   logic [15:0]  tid_i, tid_o;
   logic [1:0]   op1rw_i, op2rw_i, op3rw_i, op4rw_i, op1rw_o, op2rw_o, op3rw_o, op4rw_o;
   logic         op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
   logic         op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
   logic [83:0]  body_i, body_o;
   logic         stall_o, overflow_o, valid_o;
   logic [3:0]   count_o;
`ifdef DECODED_QUEUE_PERF_EN
   logic [31:0]  pushCount_o, popCount_o, stallCycles_o;
`endif

   decoded_inst_queue dut (
      .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
      .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(funcUnitType_i),
      .majID_i(majID_i), .minID_i(minID_i), .is64Bit_i(is64Bit_i), .pid_i(pid_i),
      .tid_i(tid_i), .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i),
      .op4rw_i(op4rw_i), .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i),
      .op3IsReg_i(op3IsReg_i), .op4IsReg_i(op4IsReg_i), .body_i(body_i),
      .stall_o(stall_o), .overflow_o(overflow_o), .valid_o(valid_o),
      .dispatchReady_i(dispatchReady_i), .opcode_o(opcode_o), .address_o(address_o),
      .funcUnitType_o(funcUnitType_o), .majID_o(majID_o), .minID_o(minID_o),
      .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o), .op1rw_o(op1rw_o),
      .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o), .op1IsReg_o(op1IsReg_o),
      .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o), .op4IsReg_o(op4IsReg_o),
      .body_o(body_o), .count_o(count_o)
`ifdef DECODED_QUEUE_PERF_EN
      , .pushCount_o(pushCount_o), .popCount_o(popCount_o), .stallCycles_o(stallCycles_o)
`endif
   );

   always #5 clock_i = ~clock_i;

   decoded_inst_t head;
   assign head = {opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o, pid_o,
                  tid_o, op4rw_o, op3rw_o, op2rw_o, op1rw_o,
                  op4IsReg_o, op3IsReg_o, op2IsReg_o, op1IsReg_o, body_o};

   decoded_inst_t sb[$];
   int n_checks = 0;
   int n_errors = 0;
   int m_count  = 0;
   logic m_over = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_entry(input string nm, input decoded_inst_t act, input decoded_inst_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got maj=%0h op=%0h body=%0h, expected maj=%0h op=%0h body=%0h",
                  nm, act.maj_id, act.opcode, act.body, exp.maj_id, exp.opcode, exp.body);
      end
   endtask

   function automatic decoded_inst_t make_entry(input logic [63:0] m);
      decoded_inst_t e;
      e.opcode    = m[5:0] ^ 6'd30;   // maj 0x10 -> opcode 14
      e.address   = 64'h1000 + (m << 2);
      e.func_unit = m[2:0];
      e.maj_id    = m;
      e.min_id    = m[3:0] + 4'd3;
      e.is_64bit  = m[0];
      e.pid       = m[19:0] * 20'd7;
      e.tid       = 16'hbeef ^ m[15:0];
      e.op_rw     = m[7:0] * 8'd5;
      e.op_is_reg = ~m[3:0];
      e.body      = {20'h5a5a5, ~m};
      return e;
   endfunction

   task automatic drive(input decoded_inst_t e);
      opcode_i = e.opcode; address_i = e.address; funcUnitType_i = e.func_unit;
      majID_i = e.maj_id; minID_i = e.min_id; is64Bit_i = e.is_64bit; pid_i = e.pid;
      tid_i = e.tid; body_i = e.body;
      op1rw_i = e.op_rw[0]; op2rw_i = e.op_rw[1]; op3rw_i = e.op_rw[2]; op4rw_i = e.op_rw[3];
      op1IsReg_i = e.op_is_reg[0]; op2IsReg_i = e.op_is_reg[1];
      op3IsReg_i = e.op_is_reg[2]; op4IsReg_i = e.op_is_reg[3];
   endtask

   task automatic check_state();
      decoded_inst_t zero;
      zero = '0;
      chk("count", 64'(count_o), 64'(m_count));
      chk("valid", 64'(valid_o), 64'(m_count != 0));
      chk("stall", 64'(stall_o), 64'(m_count >= 5));
      chk("overflow", 64'(overflow_o), 64'(m_over));
      if (sb.size() != 0) chk_entry("head", head, sb[0]);
      else                chk_entry("head_empty_zero", head, zero);
   endtask

   // One clock: apply inputs, advance the reference model at the edge, check 1 ns later.
   task automatic step(input logic en, input logic rdy, input logic fl, input logic rst,
                       input logic [63:0] maj);
      decoded_inst_t e;
      logic p_push, p_pop;
      e = make_entry(maj);
      drive(e);
      enable_i = en; dispatchReady_i = rdy; flush_i = fl; reset_i = rst;
      @(posedge clock_i);
      if (!rst) begin
         m_count = 0; m_over = 1'b0; sb.delete();
      end else if (fl) begin
         m_count = 0; sb.delete();
      end else begin
         p_pop  = (m_count != 0) && rdy;
         p_push = en && ((m_count < 8) || p_pop);
         if (p_push) sb.push_back(e);
         if (en && !p_push) m_over = 1'b1;
         m_count = m_count + int'(p_push) - int'(p_pop);
      end
      #1;
      check_state();
   endtask

   // Monitor: the head leaves on the next edge whenever valid_o && dispatchReady_i.
   always @(negedge clock_i) begin
      if (reset_i === 1'b1 && valid_o === 1'b1 && dispatchReady_i === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_unexpected: got majID %0h, expected no valid entry", majID_o);
         end else begin
            chk_entry("pop_data", head, sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b0; flush_i = 1'b0; enable_i = 1'b0; dispatchReady_i = 1'b0;
      drive(make_entry(64'd0));
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Single push, then fill to 5 (stall), 8, and drop a 9th.
      step(1, 0, 0, 1, 64'h10);
      chk("first_majID", majID_o, 64'h10);
      chk("first_opcode", 64'(opcode_o), 64'd14);
      for (int i = 1; i < 8; i++) step(1, 0, 0, 1, 64'h10 + 64'(i));
      step(1, 0, 0, 1, 64'h18);
      chk("overflow_set", 64'(overflow_o), 64'd1);
      step(0, 0, 0, 1, 0);

      // Fresh reset, fill, then push+pop while full.
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 64'h20 + 64'(i));
      step(1, 1, 0, 1, 64'h28);
      chk("full_pushpop_head", majID_o, 64'h21);
      chk("full_pushpop_count", 64'(count_o), 64'd8);
      repeat (8) step(0, 1, 0, 1, 0);

      // Steady stream across pointer wrap.
      for (int i = 0; i < 12; i++) step(1, 1, 0, 1, 64'(i));
      repeat (2) step(0, 1, 0, 1, 0);

      // Flush with a concurrent push.
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 64'h40 + 64'(i));
      step(1, 0, 1, 1, 64'h50);
      step(0, 0, 0, 1, 0);

      // Overflow, flush keeps it, then reset beats flush and clears it.
      for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 64'h60 + 64'(i));
      step(0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 64'h70 + 64'(i));
      step(0, 0, 1, 0, 0);
`ifdef DECODED_QUEUE_PERF_EN
      chk("perf_push_rst", pushCount_o, 64'd0);
      chk("perf_pop_rst", popCount_o, 64'd0);
      chk("perf_stall_rst", stallCycles_o, 64'd0);
`endif
      step(1, 1, 0, 1, 64'h80);
      step(0, 1, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
